// File: rtl/sfx_pkg.sv
// rtl/sfx_pkg.sv - shared types and constants for the sfx sequencer
// Purpose: state encoding, default tone durations and duration counter width.
// Optional feature macro: SFX_RETRIGGER_EN adds the GAP state used for jump retrigger.
package sfx_pkg;

    localparam int unsigned DUR_W           = 16;
    localparam int unsigned DEF_TICK_DIV    = 100000;
    localparam int unsigned DEF_JUMP_MS     = 150;
    localparam int unsigned DEF_DEATH_MS    = 1000;
    localparam int unsigned DEF_COOLDOWN_MS = 20;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_JUMP     = 3'd1,
        S_DEATH    = 3'd2,
`ifdef SFX_RETRIGGER_EN
        S_GAP      = 3'd3,
`endif
        S_COOLDOWN = 3'd4
    } sfx_state_t;

endpackage

// File: rtl/sfx_tick_gen.sv
// rtl/sfx_tick_gen.sv - duration tick prescaler
// Purpose: counts 0..TICK_DIV-1 and pulses tick on the last count.
// Ports:
//   clk    in  system clock
//   resetn in  synchronous active-low reset
//   clear  in  synchronous clear to 0 (wins over counting)
//   tick   out high for one cycle while the count equals TICK_DIV-1
module sfx_tick_gen #(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    output logic tick
);

    localparam int unsigned W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/sfx_sequencer.sv
// rtl/sfx_sequencer.sv - game event to sound request sequencer
// Purpose: turns jump/death event pulses into timed, prioritised jump/isdead
// request levels with an inter-sound cooldown.
// Optional feature macro: SFX_RETRIGGER_EN (jump during a jump tone restarts it
// after a 2-cycle GAP with both requests low).
// Ports:
//   CLK100MHZ  in  system clock
//   CPU_RESETN in  synchronous active-low reset
//   jump_evt   in  jump event, rising edge triggers
//   death_evt  in  death event, rising edge triggers
//   jump       out registered jump-tone request
//   isdead     out registered death-tone request
//   busy       out registered, high whenever not IDLE
module sfx_sequencer
    import sfx_pkg::*;
#(
    parameter int unsigned TICK_DIV    = DEF_TICK_DIV,
    parameter int unsigned JUMP_MS     = DEF_JUMP_MS,
    parameter int unsigned DEATH_MS    = DEF_DEATH_MS,
    parameter int unsigned COOLDOWN_MS = DEF_COOLDOWN_MS
) (
    input  logic CLK100MHZ,
    input  logic CPU_RESETN,
    input  logic jump_evt,
    input  logic death_evt,
    output logic jump,
    output logic isdead,
    output logic busy
);

    sfx_state_t       state;
    sfx_state_t       state_next;
    logic             jump_prev;
    logic             death_prev;
    logic             jump_edge;
    logic             death_edge;
    logic [DUR_W-1:0] dur_cnt;
    logic [DUR_W-1:0] load_val;
    logic             load;
    logic             tick;
    logic             expire;
`ifdef SFX_RETRIGGER_EN
    logic             gap_done;
`endif

    // Prev registers reset high so an event held through reset is not a trigger.
    assign jump_edge  = jump_evt & ~jump_prev;
    assign death_edge = death_evt & ~death_prev;
    assign expire     = tick && (dur_cnt == DUR_W'(1));

    sfx_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (CLK100MHZ),
        .resetn (CPU_RESETN),
        .clear  (load),
        .tick   (tick)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (death_edge)      state_next = S_DEATH;
                else if (jump_edge)  state_next = S_JUMP;
            end
            S_JUMP: begin
                if (death_edge)      state_next = S_DEATH;
                else if (expire)     state_next = S_COOLDOWN;
`ifdef SFX_RETRIGGER_EN
                else if (jump_edge)  state_next = S_GAP;
`endif
            end
            S_DEATH: begin
                if (expire)          state_next = S_COOLDOWN;
            end
            S_COOLDOWN: begin
                if (death_edge)      state_next = S_DEATH;
                else if (expire)     state_next = S_IDLE;
            end
`ifdef SFX_RETRIGGER_EN
            S_GAP: begin
                if (death_edge)      state_next = S_DEATH;
                else if (gap_done)   state_next = S_JUMP;
            end
`endif
            default:                 state_next = S_IDLE;
        endcase
    end

    // Every entry into a timed state restarts the prescaler and reloads the
    // duration so the first tick is always a full one.
    always_comb begin
        load     = 1'b0;
        load_val = '0;
        if (state_next != state) begin
            case (state_next)
                S_JUMP:     begin load = 1'b1; load_val = DUR_W'(JUMP_MS);     end
                S_DEATH:    begin load = 1'b1; load_val = DUR_W'(DEATH_MS);    end
                S_COOLDOWN: begin load = 1'b1; load_val = DUR_W'(COOLDOWN_MS); end
                default:    begin load = 1'b0; load_val = '0;                  end
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            state      <= S_IDLE;
            jump_prev  <= 1'b1;
            death_prev <= 1'b1;
            dur_cnt    <= '0;
            jump       <= 1'b0;
            isdead     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            jump_prev  <= jump_evt;
            death_prev <= death_evt;
            // Outputs decode the next state so they change on the same edge as the state.
            jump       <= (state_next == S_JUMP);
            isdead     <= (state_next == S_DEATH);
            busy       <= (state_next != S_IDLE);
            if (load) begin
                dur_cnt <= load_val;
            end else if (tick && (dur_cnt != '0)) begin
                dur_cnt <= dur_cnt - DUR_W'(1);
            end
        end
    end

`ifdef SFX_RETRIGGER_EN
    // GAP lasts exactly two cycles: gap_done is low on the first, high on the second.
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            gap_done <= 1'b0;
        end else begin
            gap_done <= (state == S_GAP) && (state_next == S_GAP);
        end
    end
`endif

endmodule

// File: tb/tb_sfx_sequencer.sv
// tb/tb_sfx_sequencer.sv - self-checking bench for sfx_sequencer
module tb_sfx_sequencer;

    logic clk        = 1'b0;
    logic resetn     = 1'b0;
    logic jump_evt   = 1'b0;
    logic death_evt  = 1'b0;
    logic jump;
    logic isdead;
    logic busy;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [2:0] exp_q[$];

    sfx_sequencer #(
        .TICK_DIV    (10),
        .JUMP_MS     (3),
        .DEATH_MS    (5),
        .COOLDOWN_MS (2)
    ) dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (resetn),
        .jump_evt   (jump_evt),
        .death_evt  (death_evt),
        .jump       (jump),
        .isdead     (isdead),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Expected {jump, isdead, busy} at cycle c from closed ranges.
    function automatic logic [2:0] model(int c, int jlo, int jhi, int j2lo, int j2hi,
                                         int dlo, int dhi, int blo, int bhi);
        logic j, d, b;
        j = ((c >= jlo) && (c <= jhi)) || ((c >= j2lo) && (c <= j2hi));
        d = (c >= dlo) && (c <= dhi);
        b = (c >= blo) && (c <= bhi);
        return {j, d, b};
    endfunction

    task automatic check(string tag, int c, logic [2:0] got, logic [2:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed {jump,isdead,busy}=%b expected %b", tag, c, got, exp);
        end
    endtask

    task automatic step_check(string tag, int c);
        @(posedge clk);
        #1;
        check(tag, c, {jump, isdead, busy}, exp_q.pop_front());
    endtask

    // Drive single-cycle pulses at the given cycles, checking outputs of cycles 1..n.
    task automatic play(string tag, int n, int j0, int j1, int d0,
                        int jlo, int jhi, int j2lo, int j2hi,
                        int dlo, int dhi, int blo, int bhi);
        for (int c = 0; c < n; c++) begin
            jump_evt  = (c == j0) || (c == j1);
            death_evt = (c == d0);
            exp_q.push_back(model(c + 1, jlo, jhi, j2lo, j2hi, dlo, dhi, blo, bhi));
            step_check(tag, c + 1);
        end
        jump_evt  = 1'b0;
        death_evt = 1'b0;
    endtask

    task automatic do_reset(string tag);
        resetn    = 1'b0;
        jump_evt  = 1'b0;
        death_evt = 1'b0;
        exp_q.push_back(3'b000);
        step_check(tag, 0);
        exp_q.push_back(3'b000);
        step_check(tag, 0);
        resetn = 1'b1;
        exp_q.push_back(3'b000);
        step_check({tag, "_release"}, 0);
    endtask

    initial begin
        #1;
        do_reset("reset_state");

        play("jump_only", 55, 0, -1, -1, 1, 30, 0, -1, 0, -1, 1, 50);
        do_reset("reset_a");

        play("death_only", 75, -1, -1, 0, 0, -1, 0, -1, 1, 50, 1, 70);
        do_reset("reset_b");

        play("jump_then_death", 85, 0, -1, 10, 1, 10, 0, -1, 11, 60, 1, 80);
        do_reset("reset_c");

        // Simultaneous edges, then a jump during cooldown (cycle 55) that must be ignored.
        play("simul_and_cooldown_jump", 75, 0, 55, 0, 0, -1, 0, -1, 1, 50, 1, 70);
        do_reset("reset_d");

`ifdef SFX_RETRIGGER_EN
        play("retrigger", 72, 0, 15, -1, 1, 15, 18, 47, 0, -1, 1, 67);
`else
        play("retrigger_ignored", 72, 0, 15, -1, 1, 30, 0, -1, 0, -1, 1, 50);
`endif
        do_reset("reset_e");

        // Reset asserted at cycle 20 of a death tone.
        play("death_pre_reset", 20, -1, -1, 0, 0, -1, 0, -1, 1, 20, 1, 20);
        resetn = 1'b0;
        exp_q.push_back(3'b000);
        step_check("reset_mid_tone", 21);

        // jump_evt held high through reset release must not trigger.
        jump_evt = 1'b1;
        exp_q.push_back(3'b000);
        step_check("held_in_reset", 22);
        resetn = 1'b1;
        for (int c = 0; c < 20; c++) begin
            jump_evt = 1'b1;
            exp_q.push_back(3'b000);
            step_check("held_after_release", c + 1);
        end

        // Drop and re-raise: a genuine edge still works afterwards.
        play("jump_after_hold", 8, 1, -1, -1, 2, 8, 0, -1, 0, -1, 2, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
